// File: rtl/leaf_user_stream_endpoint.sv
// ---------------------------------------------------------------------------
// leaf_user_stream_endpoint
// User-side shell for one leaf-interface input port and one output port.
// Ingress words (interface2user) are buffered in a FIFO; egress words
// (user2interface) leave from a registered output stage. Works as a plain
// loopback kernel or as the rx/tx shell around a user kernel.
//
// Optional feature macro: USER_EP_CHECKSUM_EN
//   When defined, after every FRAME_LEN data words a 32-bit running sum of
//   that frame is inserted into the egress stream. When undefined the block
//   is a pure in-order FIFO pass-through.
//
// Ports
//   clk_user                  in   user clock
//   reset                     in   asynchronous active-high reset
//   dout_leaf_interface2user  in   ingress data
//   vld_interface2user        in   ingress valid
//   ack_user2interface        out  ingress accept (registered, !full next)
//   din_leaf_user2interface   out  egress data
//   vld_user2interface        out  egress valid
//   ack_interface2user        in   egress accept
//   rx_count                  out  ingress words accepted since reset
//   tx_count                  out  egress words accepted since reset
//   fifo_level                out  ingress FIFO occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module leaf_user_stream_endpoint #(
  parameter int unsigned PAYLOAD_BITS   = 32,
  parameter int unsigned FIFO_ADDR_BITS = 4,
  parameter int unsigned FRAME_LEN      = 8
) (
  input  logic                      clk_user,
  input  logic                      reset,
  input  logic [PAYLOAD_BITS-1:0]   dout_leaf_interface2user,
  input  logic                      vld_interface2user,
  output logic                      ack_user2interface,
  output logic [PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  output logic                      vld_user2interface,
  input  logic                      ack_interface2user,
  output logic [31:0]               rx_count,
  output logic [31:0]               tx_count,
  output logic [FIFO_ADDR_BITS:0]   fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int unsigned LVL_W = FIFO_ADDR_BITS + 1;
  localparam int unsigned CNT_W = 16;

  // Elaboration-time guard on the frame length range.
  if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_frame_len_range
    $error("FRAME_LEN must be in 1..65535");
  end

  // FIFO storage and pointers (extra MSB separates full from empty).
  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [FIFO_ADDR_BITS:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    ack_q, ack_d;
  logic [PAYLOAD_BITS-1:0] dout_q;
  logic                    vld_q;
  logic [31:0]             rx_cnt_q, tx_cnt_q;

  logic                    fifo_empty;
  logic                    push;
  logic                    load_en;
  logic                    pop;
  logic                    load;
  logic [PAYLOAD_BITS-1:0] load_data;
  logic [PAYLOAD_BITS-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_head  = mem_q[rd_ptr_q[FIFO_ADDR_BITS-1:0]];
  // ack_q is only high when the FIFO has room, so this never overruns.
  assign push       = vld_interface2user && ack_q;
  // Output register may take a new word when empty or being drained.
  assign load_en    = !vld_q || ack_interface2user;

`ifdef USER_EP_CHECKSUM_EN
  typedef enum logic {ST_DATA = 1'b0, ST_CSUM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic             frame_last;

  assign frame_last = (frame_cnt_q == CNT_W'(FRAME_LEN - 1));

  // FSM state register.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) state_q <= ST_DATA;
    else       state_q <= state_d;
  end

  // FSM next state: leave DATA on the last word of a frame, return after
  // the checksum word has been loaded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DATA: if (pop && frame_last) state_d = ST_CSUM;
      ST_CSUM: if (load)              state_d = ST_DATA;
      default:                        state_d = ST_DATA;
    endcase
  end

  // FSM outputs: FIFO head in DATA, accumulator (no pop) in CSUM.
  always_comb begin
    pop       = 1'b0;
    load      = 1'b0;
    load_data = fifo_head;
    case (state_q)
      ST_DATA: begin
        pop  = load_en && !fifo_empty;
        load = pop;
      end
      ST_CSUM: begin
        load      = load_en;
        load_data = PAYLOAD_BITS'(acc_q);
      end
      default: ;
    endcase
  end

  // Frame counter and running sum.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    acc_d       = acc_q;
    if (pop) begin
      frame_cnt_d = frame_last ? '0 : frame_cnt_q + CNT_W'(1);
      acc_d       = acc_q + 32'(fifo_head);
    end else if (state_q == ST_CSUM && load) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      acc_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      acc_q       <= acc_d;
    end
  end
`else
  // Pass-through: every load pops the FIFO head.
  always_comb begin
    pop       = load_en && !fifo_empty;
    load      = pop;
    load_data = fifo_head;
  end
`endif

  // Occupancy and ingress accept for the coming cycle.
  always_comb begin
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    ack_d   = (level_d != LVL_W'(DEPTH));
  end

  // FIFO storage write; contents need no reset.
  always_ff @(posedge clk_user) begin
    if (push) mem_q[wr_ptr_q[FIFO_ADDR_BITS-1:0]] <= dout_leaf_interface2user;
  end

  // Pointers, level, ingress accept and counters.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LVL_W'(1);
      level_q  <= level_d;
      ack_q    <= ack_d;
      if (push)                         rx_cnt_q <= rx_cnt_q + 32'd1;
      if (vld_q && ack_interface2user)  tx_cnt_q <= tx_cnt_q + 32'd1;
    end
  end

  // Egress output register; holds while stalled.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else if (load) begin
      dout_q <= load_data;
      vld_q  <= 1'b1;
    end else if (ack_interface2user) begin
      vld_q  <= 1'b0;
    end
  end

  assign ack_user2interface      = ack_q;
  assign din_leaf_user2interface = dout_q;
  assign vld_user2interface      = vld_q;
  assign rx_count                = rx_cnt_q;
  assign tx_count                = tx_cnt_q;
  assign fifo_level              = level_q;

endmodule

// File: tb/tb_leaf_user_stream_endpoint.sv
// Directed self-checking bench for leaf_user_stream_endpoint.
module tb_leaf_user_stream_endpoint;

  localparam int unsigned PW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned FL = 4;

  logic          clk_user = 1'b0;
  logic          reset    = 1'b1;
  logic [PW-1:0] din_tb   = '0;
  logic          vld_in   = 1'b0;
  logic          ack_in   = 1'b0;
  logic          ack_user2interface;
  logic [PW-1:0] din_leaf_user2interface;
  logic          vld_user2interface;
  logic [31:0]   rx_count, tx_count;
  logic [AW:0]   fifo_level;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   egress_q[$];

  leaf_user_stream_endpoint #(
    .PAYLOAD_BITS(PW), .FIFO_ADDR_BITS(AW), .FRAME_LEN(FL)
  ) dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .dout_leaf_interface2user(din_tb),
    .vld_interface2user      (vld_in),
    .ack_user2interface      (ack_user2interface),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_in),
    .rx_count                (rx_count),
    .tx_count                (tx_count),
    .fifo_level              (fifo_level)
  );

  always #5 clk_user = ~clk_user;

  // Egress transfer log (values sampled before the edge updates them).
  always @(posedge clk_user) begin
    if (!reset && vld_user2interface && ack_in) egress_q.push_back(din_leaf_user2interface);
  end

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  // Offer one word and wait (bounded) until it has been accepted.
  task automatic send_word(input logic [31:0] w);
    int b;
    b = 0;
    vld_in = 1'b1;
    din_tb = w;
    while (!ack_user2interface && b < 100) begin
      step();
      b++;
    end
    n_checks++;
    if (!ack_user2interface) begin
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted within 100 cycles", w);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; vld_in = 1'b0; ack_in = 1'b0; din_tb = '0;
    step(); step();
    n_checks++; if (ack_user2interface !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b exp 0", ack_user2interface); end
    n_checks++; if (vld_user2interface !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b exp 0", vld_user2interface); end
    n_checks++; if (din_leaf_user2interface !== '0) begin n_fail++; $display("FAIL rst_din: got %h exp 0", din_leaf_user2interface); end
    n_checks++; if (rx_count !== 32'd0) begin n_fail++; $display("FAIL rst_rx: got %0d exp 0", rx_count); end
    n_checks++; if (tx_count !== 32'd0) begin n_fail++; $display("FAIL rst_tx: got %0d exp 0", tx_count); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rst_level: got %0d exp 0", fifo_level); end
    reset = 1'b0;
    #1;
    n_checks++; if (ack_user2interface !== 1'b0) begin n_fail++; $display("FAIL rel_ack_first: got %b exp 0", ack_user2interface); end
    step();
    n_checks++; if (ack_user2interface !== 1'b1) begin n_fail++; $display("FAIL rel_ack_second: got %b exp 1", ack_user2interface); end
    n_checks++; if (vld_user2interface !== 1'b0) begin n_fail++; $display("FAIL rel_vld: got %b exp 0", vld_user2interface); end
  endtask

  task automatic test_passthrough();
    egress_q.delete();
    ack_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      vld_in = 1'b1;
      din_tb = 32'(i);
      step();
      if (i == 1) begin
        n_checks++; if (vld_user2interface !== 1'b0) begin n_fail++; $display("FAIL lat_vld_n: got %b exp 0", vld_user2interface); end
      end
      if (i == 2) begin
        n_checks++;
        if (vld_user2interface !== 1'b1 || din_leaf_user2interface !== 32'h1) begin
          n_fail++; $display("FAIL lat_vld_n1: got vld=%b din=%h exp vld=1 din=1", vld_user2interface, din_leaf_user2interface);
        end
      end
    end
    vld_in = 1'b0;
    repeat (5) step();
    n_checks++; if (egress_q.size() != 16) begin n_fail++; $display("FAIL pt_count: got %0d exp 16", egress_q.size()); end
    for (int i = 0; i < egress_q.size() && i < 16; i++) begin
      n_checks++; if (egress_q[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL pt_word[%0d]: got %h exp %h", i, egress_q[i], i + 1); end
    end
    n_checks++; if (rx_count !== 32'd16) begin n_fail++; $display("FAIL pt_rx: got %0d exp 16", rx_count); end
    n_checks++; if (tx_count !== 32'd16) begin n_fail++; $display("FAIL pt_tx: got %0d exp 16", tx_count); end
  endtask

  task automatic test_backpressure();
    int sent, drop_at;
    logic [AW:0] lvl;
    logic acc;
    egress_q.delete();
    ack_in = 1'b0; sent = 0; drop_at = -1; lvl = '0;
    for (int cyc = 0; cyc < 200 && sent < 20; cyc++) begin
      if (!ack_user2interface && drop_at < 0 && sent > 0) begin
        drop_at = sent;
        lvl     = fifo_level;
        ack_in  = 1'b1;
      end
      vld_in = 1'b1;
      din_tb = 32'h100 + 32'(sent);
      acc    = ack_user2interface;
      step();
      if (acc) sent++;
    end
    vld_in = 1'b0;
    n_checks++; if (sent != 20) begin n_fail++; $display("FAIL bp_sent: got %0d exp 20", sent); end
    n_checks++; if (drop_at != 17) begin n_fail++; $display("FAIL bp_drop_at: got %0d exp 17", drop_at); end
    n_checks++; if (lvl !== 5'd16) begin n_fail++; $display("FAIL bp_level_full: got %0d exp 16", lvl); end
    repeat (30) step();
    n_checks++; if (egress_q.size() != 20) begin n_fail++; $display("FAIL bp_count: got %0d exp 20", egress_q.size()); end
    for (int i = 0; i < egress_q.size() && i < 20; i++) begin
      n_checks++; if (egress_q[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL bp_word[%0d]: got %h exp %h", i, egress_q[i], 32'h100 + 32'(i)); end
    end
    n_checks++; if (rx_count !== 32'd36) begin n_fail++; $display("FAIL bp_rx: got %0d exp 36", rx_count); end
    n_checks++; if (tx_count !== 32'd36) begin n_fail++; $display("FAIL bp_tx: got %0d exp 36", tx_count); end
  endtask

  task automatic test_toggle();
    logic [31:0] exp_q[$];
    logic [31:0] pd;
    logic pv, pa, acc;
    int sent;
    egress_q.delete();
    sent = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      ack_in = (cyc % 2) == 1;
      vld_in = (cyc % 3) != 2;
      din_tb = 32'h200 + 32'(sent);
      pv = vld_user2interface; pa = ack_in; pd = din_leaf_user2interface;
      acc = vld_in && ack_user2interface;
      step();
      if (acc) begin exp_q.push_back(din_tb); sent++; end
      if (pv && !pa) begin
        n_checks++;
        if (vld_user2interface !== 1'b1 || din_leaf_user2interface !== pd) begin
          n_fail++; $display("FAIL tg_stable: got vld=%b din=%h exp vld=1 din=%h", vld_user2interface, din_leaf_user2interface, pd);
        end
      end
    end
    vld_in = 1'b0; ack_in = 1'b1;
    repeat (30) step();
    n_checks++; if (egress_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tg_count: got %0d exp %0d", egress_q.size(), exp_q.size()); end
    for (int i = 0; i < egress_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (egress_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tg_word[%0d]: got %h exp %h", i, egress_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_checksum();
    logic [31:0] exp1 [6];
    logic [31:0] exp2 [5];
    exp1 = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hA, 32'h5};
    exp2 = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC};
    egress_q.delete();
    ack_in = 1'b1;
    for (int i = 1; i <= 5; i++) send_word(32'(i));
    vld_in = 1'b0;
    repeat (10) step();
    n_checks++; if (egress_q.size() != 6) begin n_fail++; $display("FAIL cs_count: got %0d exp 6", egress_q.size()); end
    for (int i = 0; i < egress_q.size() && i < 6; i++) begin
      n_checks++; if (egress_q[i] !== exp1[i]) begin n_fail++; $display("FAIL cs_word[%0d]: got %h exp %h", i, egress_q[i], exp1[i]); end
    end
    n_checks++; if (tx_count !== 32'd6) begin n_fail++; $display("FAIL cs_tx: got %0d exp 6", tx_count); end
    reset = 1'b1; step(); reset = 1'b0; step(); step();
    egress_q.delete();
    for (int i = 0; i < 4; i++) send_word(32'hFFFFFFFF);
    vld_in = 1'b0;
    repeat (10) step();
    n_checks++; if (egress_q.size() != 5) begin n_fail++; $display("FAIL cs2_count: got %0d exp 5", egress_q.size()); end
    for (int i = 0; i < egress_q.size() && i < 5; i++) begin
      n_checks++; if (egress_q[i] !== exp2[i]) begin n_fail++; $display("FAIL cs2_word[%0d]: got %h exp %h", i, egress_q[i], exp2[i]); end
    end
  endtask

  task automatic test_async_reset();
    int sent;
    logic acc;
    ack_in = 1'b0; sent = 0;
    for (int cyc = 0; cyc < 100 && sent < 6; cyc++) begin
      vld_in = 1'b1;
      din_tb = 32'h300 + 32'(sent);
      acc    = ack_user2interface;
      step();
      if (acc) sent++;
    end
    vld_in = 1'b0;
    n_checks++; if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL ar_level_pre: got %0d exp 5", fifo_level); end
    n_checks++; if (vld_user2interface !== 1'b1) begin n_fail++; $display("FAIL ar_vld_pre: got %b exp 1", vld_user2interface); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (vld_user2interface !== 1'b0) begin n_fail++; $display("FAIL ar_vld: got %b exp 0", vld_user2interface); end
    n_checks++; if (din_leaf_user2interface !== '0) begin n_fail++; $display("FAIL ar_din: got %h exp 0", din_leaf_user2interface); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL ar_level: got %0d exp 0", fifo_level); end
    n_checks++; if (ack_user2interface !== 1'b0) begin n_fail++; $display("FAIL ar_ack: got %b exp 0", ack_user2interface); end
    n_checks++; if (rx_count !== 32'd0) begin n_fail++; $display("FAIL ar_rx: got %0d exp 0", rx_count); end
    step();
    reset = 1'b0;
    step(); step();
    egress_q.delete();
    ack_in = 1'b1;
    send_word(32'hAB);
    vld_in = 1'b0;
    repeat (5) step();
    n_checks++; if (egress_q.size() != 1) begin n_fail++; $display("FAIL ar_post_count: got %0d exp 1", egress_q.size()); end
    if (egress_q.size() > 0) begin
      n_checks++; if (egress_q[0] !== 32'hAB) begin n_fail++; $display("FAIL ar_post_word: got %h exp ab", egress_q[0]); end
    end
  endtask

  initial begin
    test_reset();
`ifdef USER_EP_CHECKSUM_EN
    test_checksum();
`else
    test_passthrough();
    test_backpressure();
    test_toggle();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
